// File: rtl/uart_wb_master_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge.
//   - Command/response byte codes of the host protocol.
//   - State types for the command FSM and the byte PHY.
//   - rsp_byte(): selects the outgoing response byte by index.
package uart_wb_master_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_OK    = 8'hA5;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } bridge_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  // Index 0 is the status byte; indices 1..4 are read data, MSB first.
  function automatic logic [7:0] rsp_byte(input logic [2:0]  idx,
                                          input logic [7:0]  status,
                                          input logic [31:0] data);
    logic [7:0] b;
    case (idx)
      3'd1:    b = data[31:24];
      3'd2:    b = data[23:16];
      3'd3:    b = data[15:8];
      3'd4:    b = data[7:0];
      default: b = status;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_wb_master_bridge_byte_phy.sv
// uart_byte_phy: 8N1 byte deserialiser/serialiser.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   rx_i               async serial input (idle high)
//   tx_o               serial output (idle high, registered)
//   rx_valid_o         one-cycle pulse, rx_data_o holds a good byte
//   rx_data_o          last received byte
//   rx_ferr_o          one-cycle pulse, stop bit sampled low (byte dropped)
//   tx_start_i         load tx_data_i when tx_busy_o is low
//   tx_data_i          byte to send
//   tx_busy_o          frame in progress; low during the final stop-bit cycle
//                      so the next byte can follow without a gap
module uart_byte_phy #(
  parameter int unsigned BIT_DIV = 208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o
);
  import uart_wb_master_bridge_pkg::*;

  localparam int unsigned CW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(BIT_DIV / 2 - 1);

  // ---------------- RX ----------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_CNT) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A glitch shorter than half a bit returns to idle.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == LAST_CNT) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == LAST_CNT) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_ferr_o  = rx_ferr_q;
  assign rx_data_o  = rx_shift_q;

  // ---------------- TX ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign tx_last   = (tx_state_q == TX_SEND) && (tx_bit_q == 4'd9) && (tx_cnt_q == LAST_CNT);
  assign tx_busy_o = (tx_state_q == TX_SEND) && !tx_last;
  assign tx_o      = tx_shift_q[0];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_start_i && !tx_busy_o) begin
      tx_state_d = TX_SEND;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = {1'b1, tx_data_i, 1'b0};
    end else if (tx_state_q == TX_SEND) begin
      if (tx_cnt_q == LAST_CNT) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_state_d = TX_IDLE;
          tx_shift_d = '1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_wb_master_bridge.sv
// uart_wb_master_bridge: host debug initiator. Decodes binary commands from
// a UART 8N1 line and runs single Wishbone B4 classic cycles as bus master.
//   Write: 01 A3 A2 A1 A0 D3 D2 D1 D0 -> A5 (or EE)
//   Read : 02 A3 A2 A1 A0             -> A5 D3 D2 D1 D0 (or EE)
//   Other command byte                -> EE, no bus cycle
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   uart_rx_i, uart_tx_o  serial in/out, idle high
//   wbm_*                 Wishbone master (stb mirrors cyc, sel=F in a cycle)
//   busy_o                high from first command byte to last response stop bit
// Build option: define BRIDGE_TIMEOUT_EN to abort a bus cycle with no
// ack/err after TIMEOUT_CYCLES cycles (response EE).
module uart_wb_master_bridge #(
  parameter int unsigned CLK_FREQ_HZ    = 24000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);
  import uart_wb_master_bridge_pkg::*;

  localparam int unsigned BIT_DIV = CLK_FREQ_HZ / BAUD;

  logic       rx_valid, rx_ferr, tx_start, tx_busy;
  logic [7:0] rx_data, tx_data;

  uart_byte_phy #(
    .BIT_DIV (BIT_DIV)
  ) u_phy (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .rx_i       (uart_rx_i),
    .tx_o       (uart_tx_o),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .rx_ferr_o  (rx_ferr),
    .tx_start_i (tx_start),
    .tx_data_i  (tx_data),
    .tx_busy_o  (tx_busy)
  );

  bridge_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    status_q, status_d;
  logic [2:0]    rsp_len_q, rsp_len_d;
  logic [2:0]    rsp_idx_q, rsp_idx_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          tmo_hit;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Counts cycles spent in BUS; zero on the first cycle cyc is high.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != ST_BUS) tmo_q <= '0;
    else                               tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      rsp_len_q <= '0;
      rsp_idx_q <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      rsp_len_q <= rsp_len_d;
      rsp_idx_q <= rsp_idx_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    rsp_len_d = rsp_len_q;
    rsp_idx_d = rsp_idx_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    tx_start  = 1'b0;
    tx_data   = rsp_byte(rsp_idx_q, status_q, rdata_q);

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (rx_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else if (rx_data == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else begin
            status_d  = RSP_ERR;
            rsp_len_d = 3'd1;
            rsp_idx_d = '0;
            state_d   = ST_RESP;
          end
        end
      end

      ST_ADDR: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              // Bus outputs are loaded on the same edge that enters BUS.
              state_d = ST_BUS;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              sel_d   = 4'hF;
              adr_d   = {addr_d[31:2], 2'b00};
              dat_d   = wdata_q;
            end
          end
        end
      end

      ST_DATA: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 4'hF;
            adr_d   = {addr_q[31:2], 2'b00};
            dat_d   = wdata_d;
          end
        end
      end

      // Incoming bytes (including bad frames) are ignored here and in RESP.
      ST_BUS: begin
        if (wbm_ack_i || wbm_err_i || tmo_hit) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          sel_d     = '0;
          adr_d     = '0;
          dat_d     = '0;
          rsp_idx_d = '0;
          state_d   = ST_RESP;
          if (wbm_ack_i && !wbm_err_i) begin
            status_d = RSP_OK;
            if (is_wr_q) begin
              rsp_len_d = 3'd1;
            end else begin
              rsp_len_d = 3'd5;
              rdata_d   = wbm_dat_i;
            end
          end else begin
            status_d  = RSP_ERR;
            rsp_len_d = 3'd1;
          end
        end
      end

      ST_RESP: begin
        if (!tx_busy) begin
          if (rsp_idx_q == rsp_len_q) begin
            state_d = ST_IDLE;
          end else begin
            tx_start  = 1'b1;
            rsp_idx_d = rsp_idx_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_master_bridge.sv
module tb_uart_wb_master_bridge;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned BD     = CLK_HZ / BAUD;   // 16
  localparam int unsigned TMO    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, busy;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack = 1'b0;
  logic        wbm_err = 1'b0;

  always #5 clk = ~clk;

  uart_wb_master_bridge #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .BAUD           (BAUD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .uart_rx_i (uart_rx),
    .uart_tx_o (uart_tx),
    .wbm_adr_o (wbm_adr),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel),
    .wbm_we_o  (wbm_we),
    .wbm_cyc_o (wbm_cyc),
    .wbm_stb_o (wbm_stb),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack),
    .wbm_err_i (wbm_err),
    .busy_o    (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Wishbone slave model ----------------
  // mode 0: ack, 1: err, 2: ack+err together, 3: silent
  int unsigned slv_mode  = 0;
  int unsigned slv_delay = 0;
  logic [31:0] slv_rdata = '0;

  logic        cyc_prev = 1'b0;
  logic        slv_done = 1'b0;
  logic        unstable = 1'b0;
  int unsigned n_bus    = 0;
  int unsigned cyc_len  = 0;
  int unsigned stb_bad  = 0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic [3:0]  cap_sel = '0;
  logic        cap_we  = 1'b0;

  always @(negedge clk) begin
    logic fire;
    fire = 1'b0;
    cyc_prev <= wbm_cyc;
    if (wbm_stb !== wbm_cyc) stb_bad <= stb_bad + 1;
    if (wbm_cyc === 1'b1) begin
      if (!cyc_prev) begin
        n_bus    <= n_bus + 1;
        cyc_len  <= 1;
        cap_adr  <= wbm_adr;
        cap_dat  <= wbm_dat_o;
        cap_sel  <= wbm_sel;
        cap_we   <= wbm_we;
        unstable <= 1'b0;
        fire      = (slv_mode != 3) && (slv_delay == 0);
        slv_done <= fire;
      end else begin
        cyc_len <= cyc_len + 1;
        if (wbm_adr !== cap_adr || wbm_dat_o !== cap_dat ||
            wbm_sel !== cap_sel || wbm_we !== cap_we) unstable <= 1'b1;
        fire = !slv_done && (slv_mode != 3) && (cyc_len == slv_delay);
        if (fire) slv_done <= 1'b1;
      end
      wbm_ack   <= fire && (slv_mode != 1);
      wbm_err   <= fire && (slv_mode != 0);
      wbm_dat_i <= slv_rdata;
    end else begin
      wbm_ack <= 1'b0;
      wbm_err <= 1'b0;
    end
  end

  // ---------------- UART receive monitor ----------------
  logic [7:0]  mon_bytes[$];
  int unsigned mon_ferr = 0;

  initial begin : mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (BD / 2) @(negedge clk);
        for (int unsigned i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BD) @(negedge clk);
        if (uart_tx !== 1'b1) mon_ferr++;
        mon_bytes.push_back(b);
      end
    end
  end

  // ---------------- Host stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy_low(input string name);
    int unsigned n = 0;
    while (busy === 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx"},   uart_tx,   1'b1);
    check({tag, "_busy"}, busy,      1'b0);
    check({tag, "_cyc"},  wbm_cyc,   1'b0);
    check({tag, "_stb"},  wbm_stb,   1'b0);
    check({tag, "_we"},   wbm_we,    1'b0);
    check({tag, "_sel"},  wbm_sel,   4'h0);
    check({tag, "_adr"},  wbm_adr,   32'h0);
    check({tag, "_dat"},  wbm_dat_o, 32'h0);
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    logic [71:0] cmd;       // first byte at [71:64]
    int unsigned ncmd;
    int unsigned mode;
    int unsigned delay;
    logic [31:0] rdata;
    int unsigned exp_bus;   // number of bus cycles
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;   // checked only on writes
    logic        exp_we;
    int unsigned exp_len;   // cycles with cyc high
    logic [39:0] exp_rsp;   // first byte at [39:32]
    int unsigned exp_nrsp;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int unsigned v);
    vec_t        t;
    int unsigned nb0, rp, got;
    logic [7:0]  b;
    t   = vecs[v];
    nb0 = n_bus;
    rp  = mon_bytes.size();
    slv_mode  = t.mode;
    slv_delay = t.delay;
    slv_rdata = t.rdata;
    for (int unsigned i = 0; i < t.ncmd; i++) send_byte(t.cmd[71 - 8*i -: 8], 1'b1);
    check($sformatf("v%0d_busy_hi", v), busy, 1'b1);
    wait_busy_low($sformatf("v%0d_busy_lo", v));
    repeat (BD * 2) @(negedge clk);
    got = mon_bytes.size() - rp;
    check($sformatf("v%0d_nrsp", v), got, t.exp_nrsp);
    for (int unsigned i = 0; i < t.exp_nrsp; i++) begin
      b = (rp + i < mon_bytes.size()) ? mon_bytes[rp + i] : 8'hxx;
      check($sformatf("v%0d_rsp%0d", v, i), b, t.exp_rsp[39 - 8*i -: 8]);
    end
    check($sformatf("v%0d_nbus", v), n_bus - nb0, t.exp_bus);
    if (t.exp_bus != 0) begin
      check($sformatf("v%0d_adr", v),    cap_adr, t.exp_adr);
      check($sformatf("v%0d_sel", v),    cap_sel, 4'hF);
      check($sformatf("v%0d_we", v),     cap_we,  t.exp_we);
      check($sformatf("v%0d_cyclen", v), cyc_len, t.exp_len);
      check($sformatf("v%0d_stable", v), unstable, 1'b0);
      if (t.exp_we) check($sformatf("v%0d_dat", v), cap_dat, t.exp_dat);
    end
  endtask

  task automatic wait_cyc_high(input string name);
    int unsigned n = 0;
    while (wbm_cyc !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, wbm_cyc, 1'b1);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- Main sequence ----------------
  initial begin : main
    int unsigned rp, nb0;

    //           cmd                              n  mode dly rdata        bus adr           dat           we len rsp              nrsp
    vecs[0] = '{72'h01_00_00_10_00_DE_AD_BE_EF, 9, 0, 3, 32'h0,        1, 32'h0000_1000, 32'hDEAD_BEEF, 1, 4, 40'hA5_00_00_00_00, 1};
    vecs[1] = '{72'h02_00_00_10_00_00_00_00_00, 5, 0, 1, 32'h1234_5678, 1, 32'h0000_1000, 32'h0,         0, 2, 40'hA5_12_34_56_78, 5};
    vecs[2] = '{72'h7F_00_00_00_00_00_00_00_00, 1, 0, 0, 32'h0,        0, 32'h0,         32'h0,         0, 0, 40'hEE_00_00_00_00, 1};
    vecs[3] = '{72'h02_00_00_20_04_00_00_00_00, 5, 1, 0, 32'h5555_AAAA, 1, 32'h0000_2004, 32'h0,         0, 1, 40'hEE_00_00_00_00, 1};
    vecs[4] = '{72'h01_12_34_56_7B_01_02_03_04, 9, 2, 2, 32'h0,        1, 32'h1234_5678, 32'h0102_0304, 1, 3, 40'hEE_00_00_00_00, 1};
    vecs[5] = '{72'h02_AB_CD_EF_03_00_00_00_00, 5, 0, 0, 32'hCAFE_F00D, 1, 32'hABCD_EF00, 32'h0,         0, 1, 40'hA5_CA_FE_F0_0D, 5};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");

    for (int unsigned v = 0; v < 6; v++) run_vec(v);

    // Silent slave: watchdog abort, or indefinite wait ended by reset.
    rp  = mon_bytes.size();
    slv_mode = 3;
    for (int unsigned i = 0; i < 5; i++) send_byte(vecs[1].cmd[71 - 8*i -: 8], 1'b1);
    wait_cyc_high("silent_cyc_rise");
`ifdef BRIDGE_TIMEOUT_EN
    wait_busy_low("silent_busy_lo");
    repeat (BD * 2) @(negedge clk);
    check("silent_cyclen", cyc_len, TMO);
    check("silent_nrsp", mon_bytes.size() - rp, 1);
    check("silent_rsp", (mon_bytes.size() > rp) ? mon_bytes[rp] : 8'hxx, 8'hEE);
`else
    repeat (4 * TMO + 16) @(negedge clk);
    check("silent_cyc_held", wbm_cyc, 1'b1);
    check("silent_cyclen_gt", cyc_len > 4 * TMO, 1'b1);
    check("silent_nrsp", mon_bytes.size() - rp, 0);
    pulse_reset();
    check_idle_outputs("silent_rst");
`endif

    // Reset pulse while a write is on the bus: no response follows.
    rp = mon_bytes.size();
    slv_mode  = 0;
    slv_delay = 50;
    for (int unsigned i = 0; i < 9; i++) send_byte(vecs[0].cmd[71 - 8*i -: 8], 1'b1);
    wait_cyc_high("rstbus_cyc_rise");
    repeat (5) @(negedge clk);
    pulse_reset();
    check_idle_outputs("rstbus");
    repeat (BD * 12) @(negedge clk);
    check("rstbus_nrsp", mon_bytes.size() - rp, 0);
    check("rstbus_cyc_after", wbm_cyc, 1'b0);

    // Framing error in the middle of the address field.
    rp  = mon_bytes.size();
    nb0 = n_bus;
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (4) @(negedge clk);
    check_idle_outputs("ferr");
    repeat (BD * 12) @(negedge clk);
    check("ferr_nrsp", mon_bytes.size() - rp, 0);
    check("ferr_nbus", n_bus - nb0, 0);
    run_vec(1);

    check("tx_stop_bits", mon_ferr, 0);
    check("stb_eq_cyc", stb_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
